// File: rtl/ide_pio_seq.sv
// ATA PIO register-access sequencer: turns a one-cycle register request into a
// timed IDE strobe cycle (address setup, strobe pulse, hold) and acks it.
module ide_pio_seq #(
    parameter int SETUP_CYCLES = 2,
    parameter int PULSE_CYCLES = 6,
    parameter int HOLD_CYCLES  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [4:0]  addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        ack,
    output logic        busy,
    inout  wire  [15:0] ide_data_bus,
    output logic        ide_dior,
    output logic        ide_diow,
    output logic [1:0]  ide_cs,
    output logic [2:0]  ide_da
);

    localparam logic [7:0] SETUP_LD = 8'(SETUP_CYCLES - 1);
    localparam logic [7:0] PULSE_LD = 8'(PULSE_CYCLES - 1);
    localparam logic [7:0] HOLD_LD  = 8'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_e;

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] rdata_q, rdata_d;
    logic        ack_q, ack_d;
    logic        busy_q, busy_d;
    logic        dior_q, dior_d;
    logic        diow_q, diow_d;
    logic [1:0]  cs_q, cs_d;
    logic [2:0]  da_q, da_d;
    logic        oe_q, oe_d;

    // Every pin is a flop: next-cycle pin values are decided here together
    // with the state transition, so the pins change exactly on state edges.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ack_d   = 1'b0;
        busy_d  = busy_q;
        dior_d  = dior_q;
        diow_d  = diow_q;
        cs_d    = cs_q;
        da_d    = da_q;
        oe_d    = oe_q;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = SETUP;
                    cnt_d   = SETUP_LD;
                    we_d    = we;
                    wdata_d = wdata;
                    busy_d  = 1'b1;
                    cs_d    = {~addr[4], ~addr[3]};
                    da_d    = addr[2:0];
                    oe_d    = we;
                end
            end
            SETUP: begin
                if (cnt_q == 8'd0) begin
                    state_d = PULSE;
                    cnt_d   = PULSE_LD;
                    dior_d  = we_q;
                    diow_d  = ~we_q;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            PULSE: begin
                if (cnt_q == 8'd0) begin
                    state_d = HOLD;
                    cnt_d   = HOLD_LD;
                    dior_d  = 1'b1;
                    diow_d  = 1'b1;
                    // Sample on the last edge the read strobe is still low.
                    if (!we_q) rdata_d = ide_data_bus;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            HOLD: begin
                if (cnt_q == 8'd0) begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                    ack_d   = 1'b1;
                    busy_d  = 1'b0;
                    cs_d    = 2'b11;
                    da_d    = 3'd0;
                    oe_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            we_q    <= 1'b0;
            wdata_q <= 16'd0;
            rdata_q <= 16'd0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            dior_q  <= 1'b1;
            diow_q  <= 1'b1;
            cs_q    <= 2'b11;
            da_q    <= 3'd0;
            oe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            dior_q  <= dior_d;
            diow_q  <= diow_d;
            cs_q    <= cs_d;
            da_q    <= da_d;
            oe_q    <= oe_d;
        end
    end

    assign ide_data_bus = oe_q ? wdata_q : 16'bz;
    assign rdata        = rdata_q;
    assign ack          = ack_q;
    assign busy         = busy_q;
    assign ide_dior     = dior_q;
    assign ide_diow     = diow_q;
    assign ide_cs       = cs_q;
    assign ide_da       = da_q;

endmodule

// File: tb/tb_ide_pio_seq.sv
// Bench for ide_pio_seq: default-timing and 1/1/1-timing instances, each
// checked every cycle against a phase-count reference model.
module tb_ide_pio_seq;

    localparam int SC [2] = '{2, 1};
    localparam int PC [2] = '{6, 1};
    localparam int HC [2] = '{2, 1};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_i   [2] = '{1'b0, 1'b0};
    logic        we_i    [2] = '{1'b0, 1'b0};
    logic [4:0]  addr_i  [2] = '{5'd0, 5'd0};
    logic [15:0] wdata_i [2] = '{16'd0, 16'd0};
    logic [15:0] serve   [2] = '{16'd0, 16'd0};
    logic [15:0] rdata_o [2];
    logic        ack_o   [2];
    logic        busy_o  [2];
    logic        dior_o  [2];
    logic        diow_o  [2];
    logic [1:0]  cs_o    [2];
    logic [2:0]  da_o    [2];
    wire  [15:0] bus0, bus1;
    logic [15:0] bus_v   [2];

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    int ack_cnt  [2] = '{0, 0};
    int exp_acks [2] = '{0, 0};

    always #5 clk = ~clk;

    // IDE device model: drives the register value only while read strobe is low
    assign bus0 = (dior_o[0] == 1'b0) ? serve[0] : 16'bz;
    assign bus1 = (dior_o[1] == 1'b0) ? serve[1] : 16'bz;
    assign bus_v[0] = bus0;
    assign bus_v[1] = bus1;

    ide_pio_seq #(.SETUP_CYCLES(2), .PULSE_CYCLES(6), .HOLD_CYCLES(2)) u_dut0 (
        .clk(clk), .reset(reset), .req(req_i[0]), .we(we_i[0]), .addr(addr_i[0]),
        .wdata(wdata_i[0]), .rdata(rdata_o[0]), .ack(ack_o[0]), .busy(busy_o[0]),
        .ide_data_bus(bus0), .ide_dior(dior_o[0]), .ide_diow(diow_o[0]),
        .ide_cs(cs_o[0]), .ide_da(da_o[0]));

    ide_pio_seq #(.SETUP_CYCLES(1), .PULSE_CYCLES(1), .HOLD_CYCLES(1)) u_dut1 (
        .clk(clk), .reset(reset), .req(req_i[1]), .we(we_i[1]), .addr(addr_i[1]),
        .wdata(wdata_i[1]), .rdata(rdata_o[1]), .ack(ack_o[1]), .busy(busy_o[1]),
        .ide_data_bus(bus1), .ide_dior(dior_o[1]), .ide_diow(diow_o[1]),
        .ide_cs(cs_o[1]), .ide_da(da_o[1]));

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d @%0t: got %h want %h", nm, d, $time, act, exp);
        end
    endtask

    task automatic chk_undriven(input string nm, input int d);
        checks++;
        if (!(bus_v[d] === 16'bz || bus_v[d] === 16'h0000)) begin
            errors++;
            $display("FAIL %s dut%0d @%0t: got %h want undriven", nm, d, $time, bus_v[d]);
        end
    endtask

    // Reference model: t = clocks since acceptance (0 = idle). A transfer of
    // S+P+H clocks has setup at t=1..S, strobe at S+1..S+P, hold after that.
    int          t_m   [2] = '{0, 0};
    logic        ack_m [2] = '{1'b0, 1'b0};
    logic [15:0] rd_m  [2] = '{16'd0, 16'd0};
    logic        cw    [2] = '{1'b0, 1'b0};
    logic [4:0]  ca    [2] = '{5'd0, 5'd0};
    logic [15:0] cwd   [2] = '{16'd0, 16'd0};

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                t_m[d]   <= 0;
                ack_m[d] <= 1'b0;
                rd_m[d]  <= 16'd0;
            end else begin
                ack_m[d] <= 1'b0;
                if (t_m[d] == 0) begin
                    if (req_i[d]) begin
                        t_m[d] <= 1;
                        cw[d]  <= we_i[d];
                        ca[d]  <= addr_i[d];
                        cwd[d] <= wdata_i[d];
                    end
                end else if (t_m[d] == SC[d] + PC[d] + HC[d]) begin
                    t_m[d]   <= 0;
                    ack_m[d] <= 1'b1;
                end else begin
                    if (t_m[d] == SC[d] + PC[d] && !cw[d]) rd_m[d] <= serve[d];
                    t_m[d] <= t_m[d] + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                int t;
                bit act, strb;
                t    = t_m[d];
                act  = (t != 0);
                strb = act && (t > SC[d]) && (t <= SC[d] + PC[d]);
                if (ack_o[d]) ack_cnt[d]++;
                chk("busy", d, 32'(busy_o[d]), 32'(act));
                chk("ack", d, 32'(ack_o[d]), 32'(ack_m[d]));
                chk("dior", d, 32'(dior_o[d]), 32'(!(strb && !cw[d])));
                chk("diow", d, 32'(diow_o[d]), 32'(!(strb && cw[d])));
                chk("cs", d, 32'(cs_o[d]), act ? 32'({~ca[d][4], ~ca[d][3]}) : 32'd3);
                chk("da", d, 32'(da_o[d]), act ? 32'(ca[d][2:0]) : 32'd0);
                chk("rdata", d, 32'(rdata_o[d]), 32'(rd_m[d]));
                if (act && cw[d])       chk("bus_wr", d, 32'(bus_v[d]), 32'(cwd[d]));
                else if (strb && !cw[d]) chk("bus_rd", d, 32'(bus_v[d]), 32'(serve[d]));
                else                    chk_undriven("bus_z", d);
            end
        end
    end

    // Called at a negedge; presents a one-clock request.
    task automatic issue(input int d, input logic w, input logic [4:0] a,
                         input logic [15:0] wd, input logic [15:0] sv);
        we_i[d] = w; addr_i[d] = a; wdata_i[d] = wd; serve[d] = sv;
        req_i[d] = 1'b1;
        exp_acks[d]++;
        @(posedge clk);
        @(negedge clk);
        req_i[d] = 1'b0;
    endtask

    // n = negedge index since acceptance on entry; returns clocks to ack.
    task automatic wait_ack(input int d, input int n0, output int lat);
        int n;
        n = n0;
        lat = -1;
        while (n < 300) begin
            if (ack_o[d]) begin
                lat = n - 1;
                break;
            end
            @(negedge clk);
            n++;
        end
        if (lat < 0) chk("ack_timeout", d, 32'd0, 32'd1);
    endtask

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [15:0] wdata;
        logic [15:0] serve;
        logic [15:0] exp_rdata;
    } vec_t;

    vec_t tv [6];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        tv[0] = '{1'b0, 5'b01111, 16'h0000, 16'h0050, 16'h0050};
        tv[1] = '{1'b1, 5'b01000, 16'hA5C3, 16'h0000, 16'h0050};
        tv[2] = '{1'b0, 5'b00101, 16'h0000, 16'h1234, 16'h1234};
        tv[3] = '{1'b1, 5'b11010, 16'hFFFF, 16'h9999, 16'h1234};
        tv[4] = '{1'b0, 5'b10000, 16'h0000, 16'hBEEF, 16'hBEEF};
        tv[5] = '{1'b0, 5'b11110, 16'h0000, 16'h8001, 16'h8001};

        reset = 1'b1;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_dior", d, 32'(dior_o[d]), 32'd1);
            chk("rst_diow", d, 32'(diow_o[d]), 32'd1);
            chk("rst_cs", d, 32'(cs_o[d]), 32'd3);
            chk("rst_da", d, 32'(da_o[d]), 32'd0);
            chk("rst_ack", d, 32'(ack_o[d]), 32'd0);
            chk("rst_busy", d, 32'(busy_o[d]), 32'd0);
            chk("rst_rdata", d, 32'(rdata_o[d]), 32'd0);
            chk_undriven("rst_bus", d);
        end
        reset = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);

        // Directed table; each request goes out in the previous ack cycle.
        for (int i = 0; i < 6; i++) begin
            issue(0, tv[i].we, tv[i].addr, tv[i].wdata, tv[i].serve);
            wait_ack(0, 1, lat);
            chk("tbl_lat", 0, 32'(lat), 32'd10);
            chk("tbl_rdata", 0, 32'(rdata_o[0]), 32'(tv[i].exp_rdata));
        end
        repeat (3) @(negedge clk);

        // A req pulse in the middle of an access must be ignored.
        issue(0, 1'b0, 5'b01001, 16'h0, 16'h4242);
        repeat (2) @(negedge clk);
        we_i[0] = 1'b1; addr_i[0] = 5'b10011; wdata_i[0] = 16'hDEAD; req_i[0] = 1'b1;
        @(negedge clk);
        req_i[0] = 1'b0;
        wait_ack(0, 4, lat);
        chk("ign_lat", 0, 32'(lat), 32'd10);
        chk("ign_rdata", 0, 32'(rdata_o[0]), 32'h4242);
        repeat (12) @(negedge clk);

        // Reset during cycle 4 of a read (strobe low).
        issue(0, 1'b0, 5'b01111, 16'h0, 16'h5A5A);
        repeat (3) @(negedge clk);
        chk("mid_dior_low", 0, 32'(dior_o[0]), 32'd0);
        reset = 1'b1;
        exp_acks[0]--;
        @(negedge clk);
        reset = 1'b0;
        chk("mr_dior", 0, 32'(dior_o[0]), 32'd1);
        chk("mr_cs", 0, 32'(cs_o[0]), 32'd3);
        chk("mr_ack", 0, 32'(ack_o[0]), 32'd0);
        chk("mr_busy", 0, 32'(busy_o[0]), 32'd0);
        chk("mr_rdata", 0, 32'(rdata_o[0]), 32'd0);
        chk_undriven("mr_bus", 0);
        @(negedge clk);
        issue(0, 1'b0, 5'b01111, 16'h0, 16'h7E57);
        wait_ack(0, 1, lat);
        chk("post_rst_lat", 0, 32'(lat), 32'd10);
        chk("post_rst_rdata", 0, 32'(rdata_o[0]), 32'h7E57);
        @(negedge clk);

        // Minimum timing instance.
        issue(1, 1'b0, 5'b01110, 16'h0, 16'hC0DE);
        wait_ack(1, 1, lat);
        chk("min_lat", 1, 32'(lat), 32'd3);
        chk("min_rdata", 1, 32'(rdata_o[1]), 32'hC0DE);
        issue(1, 1'b1, 5'b10001, 16'h3C3C, 16'h0);
        wait_ack(1, 1, lat);
        chk("min_wr_lat", 1, 32'(lat), 32'd3);
        chk("min_wr_rdata", 1, 32'(rdata_o[1]), 32'hC0DE);

        // Random traffic on both instances, with random idle gaps.
        for (int i = 0; i < 60; i++) begin
            int d, gap;
            d   = int'($urandom_range(1, 0));
            gap = int'($urandom_range(3, 0));
            repeat (gap) @(negedge clk);
            issue(d, 1'($urandom), 5'($urandom), 16'($urandom | 1), 16'($urandom));
            wait_ack(d, 1, lat);
            chk("rnd_lat", d, 32'(lat), 32'(SC[d] + PC[d] + HC[d]));
        end

        repeat (15) @(negedge clk);
        for (int d = 0; d < 2; d++) chk("ack_count", d, 32'(ack_cnt[d]), 32'(exp_acks[d]));
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
